// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated circular transmit FIFO.
// Single clock domain; the baud rate comes from a per-bit cycle counter, not a divided clock.
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a word
// START  | start bit, line low
// DATA   | data bits, LSB first, from the shift register
// PARITY | optional parity bit over the word as loaded
// STOP   | stop bit(s), line high; chains straight into START if data waits
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 344,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W    = $clog2(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_nxt;
  logic [DATA_BITS-1:0] head, shift, shift_nxt;
  logic                 par_bit;
  logic [BAUD_W-1:0]    baud;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 push, pop, fifo_empty;
  logic                 bit_end, last_data, last_stop;
  logic                 tx_nxt, busy_nxt;

  // Handshake and frame-timing decode from registered state.
  assign in_ready   = !rst && (fifo_count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];
  assign bit_end    = (state != S_IDLE) && (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign last_stop  = (bit_cnt == BIT_W'(STOP_BITS - 1));
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop        = !fifo_empty &&
                      ((state == S_IDLE) || ((state == S_STOP) && bit_end && last_stop));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end && last_stop) state_nxt = fifo_empty ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: line level and busy flag for the cycle after this edge.
  always_comb begin
    shift_nxt = shift;
    if (pop) shift_nxt = head;
    else if ((state == S_DATA) && bit_end) shift_nxt = shift >> 1;

    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase

    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != S_IDLE) || (count_nxt != '0);
  end

  // Registered outputs; tx idles high and returns high on reset, truncating any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_busy <= busy_nxt;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nxt;
    end
  end

  // Baud and bit counters, shift register and parity captured from the popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      // Every state change happens at a bit end or out of IDLE, so this also clears on entry.
      baud  <= ((state == S_IDLE) || bit_end) ? '0 : baud + 1'b1;
      shift <= shift_nxt;
      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;
      if (pop) par_bit <= (PARITY == 2) ? ~(^head) : (^head);
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and clock-enable baud generation, replacing the divided-clock transmitter used in the LED/UART demos. Upstream logic pushes words through a valid/ready handshake. The block serialises each word LSB-first with configurable data width, parity and stop bits. Everything runs on the single board clock, with no derived clocks.

## Interface
- CLKS_PER_BIT, 344: clock cycles per serial bit (3.3 MHz / 9600 baud, rounded); legal range ≥ 2
- DATA_BITS, 8: data bits per frame; legal range 5–8
- PARITY, 0: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: stop bits per frame; legal range 1–2
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥ 2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_BITS  word to transmit
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word
- tx  out  1  serial output; idle high; registered
- tx_busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored in the FIFO

## Operation
- Push occurs on an edge where in_valid && in_ready.
  - in_ready = !rst && (fifo_count != FIFO_DEPTH).
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - in_data and in_valid are ignored when in_ready is low.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count changes by +1 on push, −1 on pop, and 0 on simultaneous push and pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO non-empty. The head word is popped into the shift register on the same edge.
  - START: tx = 0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx = shift[0]; shift right each bit; DATA_BITS bits → PARITY if PARITY != 0, else → STOP.
  - PARITY:
    - Even mode: tx = XOR of the data bits.
    - Odd mode: tx = the inverse of that XOR.
    - → STOP.
  - STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
    - On the final cycle, if the FIFO is non-empty, pop and → START with no idle gap.
    - Otherwise → IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT−1 and resets to 0 on every state entry.
  - A bit ends when the counter equals CLKS_PER_BIT−1.
  - Counter width is $clog2(CLKS_PER_BIT).
  - The counter never runs in IDLE.
- Bit counter: sized for max(DATA_BITS, STOP_BITS); cleared on state entry.
- Parity is computed from the word as loaded, not from the shifted register.
- tx_busy = (state != IDLE) || (fifo_count != 0).
- Reset (any state, including mid-frame):
  - State → IDLE, pointers and count → 0, tx → 1 at that edge.
  - The frame in progress is truncated and not resumed.
  - FIFO contents are discarded.
- Reset values: tx = 1, tx_busy = 0, fifo_count = 0, in_ready = 0 while rst is high and 1 on the first cycle after.

## Timing
- Edge numbering: push on edge E into an empty FIFO while IDLE.
  - Edge E+1: FSM pops and enters START; tx = 0 is visible after E+1.
  - fifo_count = 1 after E and 0 after E+1.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY ? 1 : 0) + STOP_BITS) cycles, exact, with no jitter.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- Capacity: up to FIFO_DEPTH words buffered plus one in the shift register.
- Pop-to-in_ready: when the FIFO is full, in_ready rises the cycle after the popping edge.
- All outputs except in_ready are registered. in_ready is combinational from registered fifo_count and rst.

## Test plan
- Reset: hold rst 3 cycles while in_valid = 1 → tx = 1, tx_busy = 0, fifo_count = 0, in_ready = 0, and no word is accepted. in_ready = 1 on the cycle after release.
- Single frame (CLKS_PER_BIT = 4, 8N1): push 0x55 at edge E.
  - tx low from E+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles.
  - tx_busy falls after E+41.
- Back-to-back: push 0x01, 0x80, 0xFF on consecutive cycles → three 40-cycle frames with no high gap between a stop bit and the next start bit. fifo_count sequence is 1, 1, 2, then decrements at each frame boundary.
- Full/backpressure (FIFO_DEPTH = 4): hold in_valid continuously.
  - Exactly 5 words are accepted before in_ready falls.
  - in_ready reasserts one cycle after the next pop at a frame boundary.
  - Total order of serialised words is preserved, including across pointer wrap after 8+ words.
- Parity and width (DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, CLKS_PER_BIT = 4): push 0x07 → data bits 1,1,1,0,0,0,0, then parity = 1, then 8 high cycles; frame length 44 cycles. With PARITY = 2, the parity bit is 0.
- Mid-frame reset: assert rst during data bit 3 with 2 words queued → tx = 1 after that edge, fifo_count = 0, tx_busy = 0, and no further frames are sent.
